neuron_engine: RTL and testbench

- Parametrised successor to the single-neuron accelerator datapath: a lane-parallel multiply-accumulate engine.
- Consumes a stream of input-neuron/weight chunks, adds a bias, applies a selectable activation, and emits one saturated output neuron over a valid/ready handshake.
- Sits between the BRAM/weight fetch FSM and the output write-back path. Generalises lane count, data/weight width, fixed-point scaling and activation mode.

---
 rtl/neuron_pkg.sv | 41 ++++
 rtl/neuron_engine_lane_sum_tree.sv | 77 +++++++
 rtl/neuron_engine.sv | 142 ++++++++++++++
 tb/tb_neuron_engine.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron MAC engine.
package neuron_pkg;

  localparam int unsigned SAT_W = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DRAIN = 3'd2,
    ACT   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  typedef enum logic {
    ACT_IDENT = 1'b0,
    ACT_RELU  = 1'b1
  } act_mode_t;

  // 00 selects identity; every other code selects relu.
  function automatic act_mode_t decode_act_mode(input logic [1:0] mode);
    return (mode == 2'b00) ? ACT_IDENT : ACT_RELU;
  endfunction

  // Binary weight: 1 -> +1, 0 -> -1.
  function automatic logic signed [1:0] decode_bin_weight(input logic w);
    return w ? 2'sb01 : 2'sb11;
  endfunction

  // Clamp x into the signed range of a w-bit value.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] x,
                                                       input int unsigned w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(64'sd1) <<< (w - 1)) - SAT_W'(64'sd1);
    lo = -hi - SAT_W'(64'sd1);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/neuron_engine_lane_sum_tree.sv
// Stage 1: per-lane products summed across all lanes, result registered.
module lane_sum_tree
  import neuron_pkg::*;
#(
  parameter int unsigned N_LANES  = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WEIGHT_W = 1,
  parameter int unsigned ACC_W    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [N_LANES*DATA_W-1:0]    neurons,
  input  logic [N_LANES*WEIGHT_W-1:0]  weights,
  output logic                         sum_valid,
  output logic signed [ACC_W-1:0]      sum
);

  logic signed [ACC_W-1:0] prod [N_LANES];
  logic signed [ACC_W-1:0] sum_c;

  generate
    if (WEIGHT_W == 1) begin : g_bin
      // Binary weights reduce to keeping or negating the neuron.
      always_comb begin
        logic signed [DATA_W-1:0] n;
        logic signed [ACC_W-1:0]  ext;
        logic signed [1:0]        w_dec;
        n     = '0;
        ext   = '0;
        w_dec = '0;
        for (int i = 0; i < int'(N_LANES); i++) begin
          n       = signed'(neurons[i*DATA_W +: DATA_W]);
          ext     = ACC_W'(n);
          w_dec   = decode_bin_weight(weights[i]);
          prod[i] = w_dec[1] ? -ext : ext;
        end
      end
    end else begin : g_mul
      // Signed multi-bit weights: full-width signed product per lane.
      always_comb begin
        logic signed [DATA_W-1:0]          n;
        logic signed [WEIGHT_W-1:0]        w;
        logic signed [DATA_W+WEIGHT_W-1:0] p;
        n = '0;
        w = '0;
        p = '0;
        for (int i = 0; i < int'(N_LANES); i++) begin
          n       = signed'(neurons[i*DATA_W +: DATA_W]);
          w       = signed'(weights[i*WEIGHT_W +: WEIGHT_W]);
          p       = n * w;
          prod[i] = ACC_W'(p);
        end
      end
    end
  endgenerate

  // Reduction across lanes; synthesis balances this into a tree.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(N_LANES); i++) begin
      sum_c = sum_c + prod[i];
    end
  end

  // Stage-1 register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_valid <= 1'b0;
      sum       <= '0;
    end else begin
      sum_valid <= in_valid;
      if (in_valid) sum <= sum_c;
    end
  end

endmodule

// File: rtl/neuron_engine.sv
// Lane-parallel MAC neuron engine: bias + sum(neuron*weight), activation, saturation.
// Optional feature macro: NEURON_SAT_EN (saturating output plus ovf port).
module neuron_engine
  import neuron_pkg::*;
#(
  parameter int unsigned N_LANES  = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WEIGHT_W = 1,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned FRAC_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DATA_W-1:0]            bias,
  input  logic [1:0]                   act_mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [N_LANES*DATA_W-1:0]    in_neurons,
  input  logic [N_LANES*WEIGHT_W-1:0]  in_weights,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_neuron,
  output logic                         busy,
  output logic [15:0]                  beat_count
`ifdef NEURON_SAT_EN
  ,
  output logic                         ovf
`endif
);

  localparam int unsigned SHIFT = (WEIGHT_W > 1) ? FRAC_W : 0;

  state_t                  state;
  state_t                  state_n;
  logic                    drain_cnt;
  logic signed [ACC_W-1:0] acc;
  act_mode_t               act_q;
  logic                    beat_fire;
  logic                    s1_valid;
  logic signed [ACC_W-1:0] s1_sum;
  logic signed [ACC_W-1:0] r_c;
  logic [DATA_W-1:0]       act_c;
`ifdef NEURON_SAT_EN
  logic signed [SAT_W-1:0] sat_c;
  logic                    ovf_c;
`endif

  assign beat_fire = in_valid && (state == ACCUM);

  lane_sum_tree #(
    .N_LANES (N_LANES),
    .DATA_W  (DATA_W),
    .WEIGHT_W(WEIGHT_W),
    .ACC_W   (ACC_W)
  ) u_lane_sum_tree (
    .clk      (clk),
    .reset    (reset),
    .in_valid (beat_fire),
    .neurons  (in_neurons),
    .weights  (in_weights),
    .sum_valid(s1_valid),
    .sum      (s1_sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = ACCUM;
      ACCUM:   if (beat_fire && in_last) state_n = DRAIN;
      DRAIN:   if (drain_cnt) state_n = ACT;
      ACT:     state_n = HOLD;
      HOLD:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Scale, activate and narrow the accumulator to the output width.
  always_comb begin
    r_c = acc >>> SHIFT;
    if (act_q == ACT_RELU && r_c < 0) r_c = '0;
`ifdef NEURON_SAT_EN
    sat_c = saturate(SAT_W'(r_c), DATA_W);
    act_c = DATA_W'(sat_c);
    ovf_c = (sat_c != SAT_W'(r_c));
`else
    act_c = DATA_W'(r_c);
`endif
  end

  // Accumulator, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      act_q      <= ACT_IDENT;
      drain_cnt  <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_neuron <= '0;
      beat_count <= '0;
`ifdef NEURON_SAT_EN
      ovf        <= 1'b0;
`endif
    end else begin
      in_ready  <= (state_n == ACCUM);
      busy      <= (state_n != IDLE);
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;

      if (state == IDLE && start) begin
        acc        <= ACC_W'(signed'(bias)) <<< SHIFT;
        act_q      <= decode_act_mode(act_mode);
        beat_count <= '0;
      end else begin
        if (s1_valid) acc <= acc + s1_sum;
        if (beat_fire && beat_count != 16'hFFFF) beat_count <= beat_count + 16'd1;
      end

      if (state == ACT) begin
        out_valid  <= 1'b1;
        out_neuron <= act_c;
`ifdef NEURON_SAT_EN
        ovf        <= ovf_c;
`endif
      end else if (state == HOLD && out_ready) begin
        out_valid  <= 1'b0;
`ifdef NEURON_SAT_EN
        ovf        <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_neuron_engine.sv
// Directed testbench for neuron_engine (binary-weight and 8-bit-weight instances).
module tb_neuron_engine;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   bias;
  logic [1:0]    act_mode;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [255:0]  in_neurons;
  logic [15:0]   in_weights;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_neuron;
  logic          busy;
  logic [15:0]   beat_count;

  logic          m_start;
  logic [15:0]   m_bias;
  logic          m_in_valid;
  logic          m_in_ready;
  logic          m_in_last;
  logic [255:0]  m_in_neurons;
  logic [127:0]  m_in_weights;
  logic          m_out_valid;
  logic [15:0]   m_out_neuron;
  logic          m_busy;
  logic [15:0]   m_beat_count;
`ifdef NEURON_SAT_EN
  logic          ovf;
  logic          m_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_engine dut (
    .clk(clk), .reset(reset), .start(start), .bias(bias), .act_mode(act_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_neurons(in_neurons), .in_weights(in_weights),
    .out_valid(out_valid), .out_ready(out_ready), .out_neuron(out_neuron),
    .busy(busy), .beat_count(beat_count)
`ifdef NEURON_SAT_EN
    , .ovf(ovf)
`endif
  );

  neuron_engine #(.WEIGHT_W(8), .FRAC_W(4)) dut_m (
    .clk(clk), .reset(reset), .start(m_start), .bias(m_bias), .act_mode(2'b00),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_last(m_in_last),
    .in_neurons(m_in_neurons), .in_weights(m_in_weights),
    .out_valid(m_out_valid), .out_ready(1'b1), .out_neuron(m_out_neuron),
    .busy(m_busy), .beat_count(m_beat_count)
`ifdef NEURON_SAT_EN
    , .ovf(m_ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_neuron(input logic [15:0] b, input logic [1:0] m);
    bias = b; act_mode = m; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] nv, input logic [15:0] wv, input logic last);
    int guard = 0;
    while (!in_ready && guard < 20) begin tick(); guard++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_beat_ready: in_ready=%0b required 1", in_ready);
    end
    in_neurons = {16{nv}}; in_weights = wv; in_valid = 1'b1; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Counts cycles from the one following the accepted last beat until out_valid.
  task automatic wait_out(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 50) begin tick(); cyc++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL wait_out: out_valid never rose within %0d cycles", cyc);
    end
  endtask

  task automatic pop_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_neuron !== 16'h0) begin errors++; $display("FAIL reset_out_neuron: got %h want 0000", out_neuron); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (beat_count !== 16'h0) begin errors++; $display("FAIL reset_beat_count: got %0d want 0", beat_count); end
`ifdef NEURON_SAT_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
`endif
  endtask

  task automatic test_sum_latency();
    int cyc;
    start_neuron(16'd0, 2'b00);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL accum_in_ready: got %0b want 1", in_ready); end
    send_beat(16'd1, 16'hFFFF, 1'b1);
    wait_out(cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL latency: got %0d cycles want 4", cyc); end
    checks++; if (out_neuron !== 16'd16) begin errors++; $display("FAIL sum_one_beat: got %0d want 16", out_neuron); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %0b want 1", busy); end
    pop_out();
  endtask

  task automatic test_activation();
    int cyc;
    start_neuron(16'd0, 2'b00);
    send_beat(16'd1, 16'h0000, 1'b1);
    wait_out(cyc);
    checks++; if (out_neuron !== 16'hFFF0) begin errors++; $display("FAIL act_identity: got %h want fff0", out_neuron); end
    pop_out();
    start_neuron(16'd0, 2'b01);
    send_beat(16'd1, 16'h0000, 1'b1);
    wait_out(cyc);
    checks++; if (out_neuron !== 16'h0000) begin errors++; $display("FAIL act_relu01: got %h want 0000", out_neuron); end
    pop_out();
    start_neuron(16'd0, 2'b10);
    send_beat(16'd1, 16'h0000, 1'b1);
    wait_out(cyc);
    checks++; if (out_neuron !== 16'h0000) begin errors++; $display("FAIL act_relu10: got %h want 0000", out_neuron); end
    pop_out();
    start_neuron(16'd0, 2'b11);
    send_beat(16'd2, 16'hFFFF, 1'b1);
    wait_out(cyc);
    checks++; if (out_neuron !== 16'd32) begin errors++; $display("FAIL act_relu_pos: got %0d want 32", out_neuron); end
    pop_out();
  endtask

  task automatic test_multi_beat();
    int cyc;
    start_neuron(16'd5, 2'b00);
    send_beat(16'd100, 16'hFFFF, 1'b0);
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL gap_in_ready: got %0b want 1", in_ready); end
    send_beat(16'd100, 16'hFFFF, 1'b0);
    tick(); tick();
    send_beat(16'd100, 16'hFFFF, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready: got %0b want 0", in_ready); end
    wait_out(cyc);
    checks++; if (out_neuron !== 16'd4805) begin errors++; $display("FAIL multi_beat_sum: got %0d want 4805", out_neuron); end
    checks++; if (beat_count !== 16'd3) begin errors++; $display("FAIL multi_beat_count: got %0d want 3", beat_count); end
    pop_out();
  endtask

  task automatic test_saturation();
    int cyc;
    start_neuron(16'd0, 2'b00);
    for (int i = 0; i < 4; i++) send_beat(16'h7FFF, 16'hFFFF, (i == 3));
    wait_out(cyc);
`ifdef NEURON_SAT_EN
    checks++; if (out_neuron !== 16'h7FFF) begin errors++; $display("FAIL sat_value: got %h want 7fff", out_neuron); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %0b want 1", ovf); end
`else
    checks++; if (out_neuron !== 16'hFFC0) begin errors++; $display("FAIL wrap_value: got %h want ffc0", out_neuron); end
`endif
    pop_out();
`ifdef NEURON_SAT_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b want 0", ovf); end
`endif
  endtask

  task automatic run_m(input logic [15:0] b, input logic [15:0] n0, input logic [7:0] w0,
                       input logic [15:0] expv, input string name);
    int guard = 0;
    m_bias = b; m_start = 1'b1;
    tick();
    m_start = 1'b0;
    m_in_neurons = 256'(n0); m_in_weights = 128'(w0); m_in_valid = 1'b1; m_in_last = 1'b1;
    tick();
    m_in_valid = 1'b0; m_in_last = 1'b0;
    while (!m_out_valid && guard < 50) begin tick(); guard++; end
    checks++;
    if (!m_out_valid) begin
      errors++; $display("FAIL %s: out_valid never rose", name);
    end else if (m_out_neuron !== expv) begin
      errors++; $display("FAIL %s: got %0d want %0d", name, $signed(m_out_neuron), $signed(expv));
    end
    tick();
  endtask

  task automatic test_multibit();
    run_m(16'd2, 16'd10, 8'h18, 16'd17, "multibit_pos");
    run_m(16'd0, 16'hFFF8, 8'hF0, 16'd8, "multibit_neg");
  endtask

  task automatic test_backpressure();
    int cyc;
    start_neuron(16'd0, 2'b00);
    send_beat(16'd3, 16'hFFFF, 1'b1);
    wait_out(cyc);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_neuron !== 16'd48) begin
        errors++; $display("FAIL backpressure_hold%0d: valid=%0b neuron=%0d want 1/48", i, out_valid, out_neuron);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %0b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_in_hold_ignored: busy=%0b want 0", busy); end
    tick();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL stay_idle: busy=%0b in_ready=%0b want 0/0", busy, in_ready); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    start_neuron(16'd0, 2'b00);
    send_beat(16'd50, 16'hFFFF, 1'b0);
    send_beat(16'd50, 16'hFFFF, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_neuron !== 16'h0 || beat_count !== 16'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: valid=%0b neuron=%0d count=%0d busy=%0b ready=%0b want all 0",
               out_valid, out_neuron, beat_count, busy, in_ready);
    end
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_no_output: got %0b want 0", out_valid); end
    start_neuron(16'd7, 2'b00);
    send_beat(16'd2, 16'hFFFF, 1'b1);
    wait_out(cyc);
    checks++; if (out_neuron !== 16'd39) begin errors++; $display("FAIL after_reset_sum: got %0d want 39", out_neuron); end
    checks++; if (beat_count !== 16'd1) begin errors++; $display("FAIL after_reset_count: got %0d want 1", beat_count); end
    pop_out();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bias = '0; act_mode = 2'b00;
    in_valid = 1'b0; in_last = 1'b0; in_neurons = '0; in_weights = '0; out_ready = 1'b0;
    m_start = 1'b0; m_bias = '0; m_in_valid = 1'b0; m_in_last = 1'b0;
    m_in_neurons = '0; m_in_weights = '0;
    test_reset();
    test_sum_latency();
    test_activation();
    test_multi_beat();
    test_saturation();
    test_multibit();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
